// File: rtl/biriscv_fetch_mq_if.sv
// Fetch-unit bus: branch/predictor inputs, I-cache request/response and decode-side outputs.
// master is the fetch unit, slave is the surrounding front end / I-cache / decode.
interface biriscv_fetch_mq_if;
    logic        branch_request_i;
    logic [31:0] branch_pc_i;
    logic [1:0]  branch_priv_i;
    logic [31:0] next_pc_f_i;
    logic [1:0]  next_taken_f_i;
    logic        fetch_invalidate_i;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic        icache_error_i;
    logic        icache_page_fault_i;
    logic [63:0] icache_inst_i;
    logic        fetch_accept_i;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic [1:0]  icache_priv_o;
    logic        icache_flush_o;
    logic [31:0] pc_f_o;
    logic        pc_accept_o;
    logic        fetch_valid_o;
    logic [63:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic [1:0]  fetch_pred_branch_o;
    logic        fetch_fault_fetch_o;
    logic        fetch_fault_page_o;

    modport master (
        input  branch_request_i, branch_pc_i, branch_priv_i, next_pc_f_i, next_taken_f_i,
        input  fetch_invalidate_i, icache_accept_i, icache_valid_i, icache_error_i,
        input  icache_page_fault_i, icache_inst_i, fetch_accept_i,
        output icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o, pc_f_o, pc_accept_o,
        output fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_branch_o,
        output fetch_fault_fetch_o, fetch_fault_page_o
    );

    modport slave (
        output branch_request_i, branch_pc_i, branch_priv_i, next_pc_f_i, next_taken_f_i,
        output fetch_invalidate_i, icache_accept_i, icache_valid_i, icache_error_i,
        output icache_page_fault_i, icache_inst_i, fetch_accept_i,
        input  icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o, pc_f_o, pc_accept_o,
        input  fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_pred_branch_o,
        input  fetch_fault_fetch_o, fetch_fault_page_o
    );
endinterface

// File: rtl/biriscv_fetch_mq.sv
// Multi-outstanding instruction fetch: tag FIFO for in-flight reads, credit-based response FIFO,
// and stale-response dropping by count so a redirect never waits for the I-cache to drain.
module biriscv_fetch_mq #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned BUF_DEPTH       = 4
) (
    input logic                clk_i,
    input logic                rst_ni,
    biriscv_fetch_mq_if.master bus
);
    localparam logic [1:0]  PRIV_MACHINE = 2'b11;
    localparam int unsigned CNT_W        = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TAG_AW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned TAG_N        = 1 << TAG_AW;
    localparam int unsigned BUF_AW       = $clog2(BUF_DEPTH);

    typedef struct packed {
        logic [28:0] pc;
        logic [1:0]  taken;
    } tag_t;

    typedef struct packed {
        logic        page_fault;
        logic        error;
        logic [1:0]  pred;
        logic [28:0] pc;
        logic [63:0] inst;
    } resp_t;

    logic              active_q, active_d;
    logic [31:0]       pc_f_q, pc_f_d;
    logic [1:0]        priv_q, priv_d;
    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    tag_t              tag_mem_q [TAG_N];
    logic [TAG_AW-1:0] tag_wr_q, tag_wr_d;
    logic [TAG_AW-1:0] tag_rd_q, tag_rd_d;

    resp_t             buf_mem_q [BUF_DEPTH];
    logic [BUF_AW:0]   buf_wr_q, buf_wr_d;
    logic [BUF_AW:0]   buf_rd_q, buf_rd_d;
    logic [BUF_AW:0]   buf_count;

    logic              branch;
    logic              flush_req;
    logic              flush_busy;
    logic              read_req;
    logic              read_fire;
    logic              resp_valid;
    logic              resp_keep;
    logic              resp_drop;
    logic              buf_empty;
    logic              buf_pop;
    logic [31:0]       credit_used;
    tag_t              tag_new;
    tag_t              tag_head;
    resp_t             resp_ent;
    resp_t             buf_head;

    assign branch     = bus.branch_request_i;
    assign resp_valid = bus.icache_valid_i;
    assign flush_req  = bus.fetch_invalidate_i | flush_pend_q;
    assign flush_busy = flush_req;

    assign buf_count = buf_wr_q - buf_rd_q;
    assign buf_empty = (buf_wr_q == buf_rd_q);
    assign buf_head  = buf_mem_q[buf_rd_q[BUF_AW-1:0]];
    assign buf_pop   = bus.fetch_accept_i & ~buf_empty & ~branch;

    // Credits cover buffered packets plus every live (non-stale) read, so a push always fits.
    assign credit_used = 32'(buf_count) + 32'(out_q) - 32'(drop_q);

    assign read_req  = active_q & ~branch & ~flush_busy &
                       (32'(out_q) < MAX_OUTSTANDING) & (credit_used < BUF_DEPTH);
    assign read_fire = read_req & bus.icache_accept_i;

    assign tag_new  = {pc_f_q[31:3], bus.next_taken_f_i};
    assign tag_head = tag_mem_q[tag_rd_q];

    // A response in the redirect cycle is stale by definition.
    assign resp_drop = resp_valid & (branch | (drop_q != '0));
    assign resp_keep = resp_valid & ~resp_drop;
    assign resp_ent  = {bus.icache_page_fault_i, bus.icache_error_i, tag_head.taken,
                        tag_head.pc, bus.icache_inst_i};

    always_comb begin
        active_d = active_q | branch;
        pc_f_d   = pc_f_q;
        priv_d   = priv_q;
        if (branch) begin
            pc_f_d = bus.branch_pc_i;
            priv_d = bus.branch_priv_i;
        end else if (read_fire) begin
            pc_f_d = bus.next_pc_f_i;
        end
    end

    always_comb begin
        flush_pend_d = flush_req & ~bus.icache_accept_i;
    end

    always_comb begin
        out_d = out_q;
        if (read_fire && !resp_valid) begin
            out_d = out_q + CNT_W'(1);
        end else if (!read_fire && resp_valid) begin
            out_d = out_q - CNT_W'(1);
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (branch) begin
            drop_d = out_q - CNT_W'(resp_valid);
        end else if (resp_valid && drop_q != '0) begin
            drop_d = drop_q - CNT_W'(1);
        end
    end

    always_comb begin
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        if (read_fire) begin
            tag_wr_d = tag_wr_q + TAG_AW'(1);
        end
        if (resp_valid) begin
            tag_rd_d = tag_rd_q + TAG_AW'(1);
        end
    end

    always_comb begin
        buf_wr_d = buf_wr_q;
        buf_rd_d = buf_rd_q;
        if (resp_keep) begin
            buf_wr_d = buf_wr_q + (BUF_AW + 1)'(1);
        end
        if (branch) begin
            buf_rd_d = buf_wr_q;
        end else if (buf_pop) begin
            buf_rd_d = buf_rd_q + (BUF_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q     <= 1'b0;
            pc_f_q       <= '0;
            priv_q       <= PRIV_MACHINE;
            flush_pend_q <= 1'b0;
            out_q        <= '0;
            drop_q       <= '0;
            tag_wr_q     <= '0;
            tag_rd_q     <= '0;
            buf_wr_q     <= '0;
            buf_rd_q     <= '0;
        end else begin
            active_q     <= active_d;
            pc_f_q       <= pc_f_d;
            priv_q       <= priv_d;
            flush_pend_q <= flush_pend_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            tag_wr_q     <= tag_wr_d;
            tag_rd_q     <= tag_rd_d;
            buf_wr_q     <= buf_wr_d;
            buf_rd_q     <= buf_rd_d;
        end
    end

    // Storage is cleared too, so head fields read 0 straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TAG_N; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else if (read_fire) begin
            tag_mem_q[tag_wr_q] <= tag_new;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem_q[i] <= '0;
            end
        end else if (resp_keep) begin
            buf_mem_q[buf_wr_q[BUF_AW-1:0]] <= resp_ent;
        end
    end

    assign bus.icache_rd_o         = read_req;
    assign bus.icache_pc_o         = {pc_f_q[31:3], 3'b000};
    assign bus.icache_priv_o       = priv_q;
    assign bus.icache_flush_o      = flush_req;
    assign bus.pc_f_o              = pc_f_q;
    assign bus.pc_accept_o         = read_fire;
    assign bus.fetch_valid_o       = ~buf_empty;
    assign bus.fetch_instr_o       = buf_head.inst;
    assign bus.fetch_pc_o          = {buf_head.pc, 3'b000};
    assign bus.fetch_pred_branch_o = buf_head.pred;
    assign bus.fetch_fault_fetch_o = buf_head.error;
    assign bus.fetch_fault_page_o  = buf_head.page_fault;
endmodule
